// File: rtl/vedic_pkg.sv
// Shared widths and partial-product bundle for the Vedic multiplier pipeline.
// combine_pp merges the four 3x3 products into the 12-bit result.
package vedic_pkg;

  localparam int OPW   = 6;
  localparam int HALFW = 3;
  localparam int PW    = 12;
  localparam int PPW   = 6;

  typedef struct packed {
    logic [PPW-1:0] hh;
    logic [PPW-1:0] hl;
    logic [PPW-1:0] lh;
    logic [PPW-1:0] ll;
  } pp_t;

  // Cross terms are summed first so one 7-bit value is shifted into the middle.
  function automatic logic [PW-1:0] combine_pp(input pp_t pp);
    logic [PPW:0] mid;
    mid = {1'b0, pp.hl} + {1'b0, pp.lh};
    return {pp.hh, 6'b0} + {2'b0, mid, 3'b0} + {6'b0, pp.ll};
  endfunction

endpackage

// File: rtl/vedic_mult_3x3.sv
// Combinational 3x3 Urdhva-Tiryagbhyam multiplier: column-wise vertical and
// crosswise bit products, with each column carry rippling into the next.
module vedic_mult_3x3
  import vedic_pkg::*;
(
  input  logic [HALFW-1:0] a,
  input  logic [HALFW-1:0] b,
  output logic [PPW-1:0]   p
);

  logic [1:0] col1;
  logic [2:0] col2;
  logic [2:0] col3;
  logic [1:0] col4;

  always_comb begin
    col1 = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
    col2 = {2'b0, a[2] & b[0]} + {2'b0, a[1] & b[1]} + {2'b0, a[0] & b[2]}
         + {2'b0, col1[1]};
    col3 = {2'b0, a[2] & b[1]} + {2'b0, a[1] & b[2]} + {1'b0, col2[2:1]};
    col4 = {1'b0, a[2] & b[2]} + col3[2:1];
    p    = {col4, col3[0], col2[0], col1[0], a[0] & b[0]};
  end

endmodule

// File: rtl/vedic_mult_6x6_pipe.sv
// Three-stage elastic 6x6 Vedic multiplier: operand register, partial-product
// register fed by four 3x3 multipliers, and a registered final adder.
module vedic_mult_6x6_pipe
  import vedic_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  p
);

  logic [OPW-1:0] a1_q, a1_d, b1_q, b1_d;
  logic           v1_q, v1_d;
  pp_t            pp2_q, pp2_d;
  logic           v2_q, v2_d;
  logic [PW-1:0]  p3_q, p3_d;
  logic           v3_q, v3_d;
  logic           rdy1, rdy2, rdy3;
  pp_t            pp_comb;

  vedic_mult_3x3 u_ll (.a(a1_q[2:0]), .b(b1_q[2:0]), .p(pp_comb.ll));
  vedic_mult_3x3 u_hl (.a(a1_q[5:3]), .b(b1_q[2:0]), .p(pp_comb.hl));
  vedic_mult_3x3 u_lh (.a(a1_q[2:0]), .b(b1_q[5:3]), .p(pp_comb.lh));
  vedic_mult_3x3 u_hh (.a(a1_q[5:3]), .b(b1_q[5:3]), .p(pp_comb.hh));

  // Ready ripples back from the consumer, so a full pipe still accepts on a pop.
  always_comb begin
    rdy3     = !v3_q | out_ready;
    rdy2     = !v2_q | rdy3;
    rdy1     = !v1_q | rdy2;
    in_ready = rdy1 & !flush;

    a1_d  = a1_q;
    b1_d  = b1_q;
    v1_d  = v1_q;
    pp2_d = pp2_q;
    v2_d  = v2_q;
    p3_d  = p3_q;
    v3_d  = v3_q;

    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end else begin
      if (rdy1) begin
        v1_d = in_valid;
        if (in_valid) begin
          a1_d = a;
          b1_d = b;
        end
      end
      if (rdy2) begin
        v2_d = v1_q;
        if (v1_q) pp2_d = pp_comb;
      end
      if (rdy3) begin
        v3_d = v2_q;
        if (v2_q) p3_d = combine_pp(pp2_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q  <= '0;
      b1_q  <= '0;
      v1_q  <= 1'b0;
      pp2_q <= '0;
      v2_q  <= 1'b0;
      p3_q  <= '0;
      v3_q  <= 1'b0;
    end else begin
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      v1_q  <= v1_d;
      pp2_q <= pp2_d;
      v2_q  <= v2_d;
      p3_q  <= p3_d;
      v3_q  <= v3_d;
    end
  end

  assign out_valid = v3_q;
  assign p         = p3_q;

endmodule

// File: tb/tb_vedic_mult_6x6_pipe.sv
// Self-checking bench for vedic_mult_6x6_pipe: directed vector table, exhaustive
// stream, latency, backpressure, flush, async reset and random handshake runs.
module tb_vedic_mult_6x6_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;

  int checks   = 0;
  int failures = 0;

  logic [11:0] expQ[$];

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] p;
  } vec_t;

  vec_t vecTable[14];

  always #5 clk = ~clk;

  vedic_mult_6x6_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p)
  );

  task automatic checkOutput(input string name, input logic [11:0] actual,
                             input logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Every output transfer is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: actual p=%0d required no output", p);
      end else begin
        checkOutput("stream_p", p, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] ai, input logic [5:0] bi,
                               input logic [11:0] expP);
    int waitCycles = 0;
    a        = ai;
    b        = bi;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: actual in_ready=0 required 1 (a=%0d b=%0d)", ai, bi);
    end else begin
      expQ.push_back(expP);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drainOut();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
    checkOutput("drain_remaining", 12'(expQ.size()), 12'd0);
    expQ.delete();
    @(negedge clk);
    checkOutput("idle_out_valid", {11'b0, out_valid}, 12'd0);
    tick();
  endtask

  task automatic latencyCheck(input logic [5:0] ai, input logic [5:0] bi,
                              input logic [11:0] expP);
    out_ready = 1'b1;
    a         = ai;
    b         = bi;
    in_valid  = 1'b1;
    @(negedge clk);
    checkOutput("lat_in_ready", {11'b0, in_ready}, 12'd1);
    if (in_ready) expQ.push_back(expP);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lat_out_valid_c%0d", k), {11'b0, out_valid},
                  (k == 3) ? 12'd1 : 12'd0);
      if (k == 3) checkOutput("lat_p", p, expP);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual time=%0t required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        pending;
    logic [11:0] prod;

    vecTable[0]  = '{6'd45, 6'd27, 12'd1215};
    vecTable[1]  = '{6'd63, 6'd63, 12'd3969};
    vecTable[2]  = '{6'd0,  6'd63, 12'd0};
    vecTable[3]  = '{6'd63, 6'd0,  12'd0};
    vecTable[4]  = '{6'd1,  6'd1,  12'd1};
    vecTable[5]  = '{6'd7,  6'd7,  12'd49};
    vecTable[6]  = '{6'd8,  6'd8,  12'd64};
    vecTable[7]  = '{6'd56, 6'd56, 12'd3136};
    vecTable[8]  = '{6'd38, 6'd25, 12'd950};
    vecTable[9]  = '{6'd21, 6'd42, 12'd882};
    vecTable[10] = '{6'd63, 6'd1,  12'd63};
    vecTable[11] = '{6'd32, 6'd33, 12'd1056};
    vecTable[12] = '{6'd12, 6'd13, 12'd156};
    vecTable[13] = '{6'd5,  6'd3,  12'd15};

    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1 rst_n = 1'b0;
    #3;
    checkOutput("reset_out_valid", {11'b0, out_valid}, 12'd0);
    checkOutput("reset_p", p, 12'd0);
    checkOutput("reset_in_ready", {11'b0, in_ready}, 12'd1);
    #8 rst_n = 1'b1;
    tick();

    $display("[TB] directed vector table");
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(vecTable[i].a, vecTable[i].b, vecTable[i].p);
    drainOut();

    $display("[TB] exhaustive back-to-back stream");
    out_ready = 1'b1;
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) applyStimulus(6'(ia), 6'(ib), 12'(ia * ib));
    end
    drainOut();

    $display("[TB] single-op latency");
    latencyCheck(6'd5, 6'd3, 12'd15);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a        = 6'(i);
      b        = 6'd2;
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("bp_in_ready_%0d", i), {11'b0, in_ready}, 12'd1);
      if (in_ready) expQ.push_back(12'(i * 2));
      tick();
    end
    a = 6'd4;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      checkOutput("bp_full_in_ready", {11'b0, in_ready}, 12'd0);
      checkOutput("bp_hold_out_valid", {11'b0, out_valid}, 12'd1);
      checkOutput("bp_hold_p", p, 12'd2);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 4; i <= 6; i++) applyStimulus(6'(i), 6'd2, 12'(i * 2));
    drainOut();

    $display("[TB] flush");
    out_ready = 1'b0;
    applyStimulus(6'd7, 6'd7, 12'd49);
    applyStimulus(6'd10, 6'd11, 12'd110);
    applyStimulus(6'd20, 6'd3, 12'd60);
    a        = 6'd9;
    b        = 6'd9;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", {11'b0, in_ready}, 12'd0);
    tick();
    expQ.delete();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", {11'b0, out_valid}, 12'd0);
    checkOutput("flush_in_ready_after", {11'b0, in_ready}, 12'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("flush_no_leak", {11'b0, out_valid}, 12'd0);
    end
    tick();

    $display("[TB] async reset mid-stream");
    out_ready = 1'b1;
    applyStimulus(6'd11, 6'd13, 12'd143);
    applyStimulus(6'd14, 6'd15, 12'd210);
    applyStimulus(6'd17, 6'd19, 12'd323);
    applyStimulus(6'd22, 6'd23, 12'd506);
    checkOutput("pre_reset_out_valid", {11'b0, out_valid}, 12'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", {11'b0, out_valid}, 12'd0);
    checkOutput("async_rst_p", p, 12'd0);
    checkOutput("async_rst_in_ready", {11'b0, in_ready}, 12'd1);
    expQ.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    latencyCheck(6'd63, 6'd1, 12'd63);

    $display("[TB] random valid/ready");
    pending = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!pending) begin
        a        = 6'($urandom_range(0, 63));
        b        = 6'($urandom_range(0, 63));
        in_valid = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        prod = {6'b0, a} * {6'b0, b};
        expQ.push_back(prod);
        pending = 1'b0;
      end else begin
        pending = in_valid;
      end
      tick();
    end
    drainOut();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
